seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display driver, the successor to the fixed 8-digit scanner. It time-multiplexes NUM_DIGITS hex digits onto a shared 8-bit segment bus. Features: per-digit decimal point, per-digit blanking, leading-zero suppression, PWM brightness, and tear-free frame-synchronous data update. It sits between the counter/datapath blocks and the board's digit-enable and segment pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_if.sv | 28 ++
 rtl/seg_scan_timer.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment bit
// positions and the hex-to-segment decode table.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam int SEG_W  = 8;

  // Entry n occupies bits [7n+6:7n], active-high gfedcba
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_G:SEG_A] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[int'(nibble)*7 +: 7];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Data-in / display-out bundle of the scan controller; the datapath side is
// master, the display driver is slave.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_suppress;
  logic [BRIGHT_W-1:0]     bright;
  logic                    load;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   en;
  logic [SEG_W-1:0]        cx;

  modport master (
    output digits, dp_mask, blank_mask, lz_suppress, bright, load,
    input  frame_start, en, cx
  );

  modport slave (
    input  digits, dp_mask, blank_mask, lz_suppress, bright, load,
    output frame_start, en, cx
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Scan timebase: sub-phase divider, brightness phase and digit index, with a
// strobe on the last cycle of each frame.
module seg_scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int SUB_DIV    = 1562,
  parameter int BRIGHT_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [BRIGHT_W-1:0]           phase,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          boundary
);
  localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [SUB_W-1:0] sub_cnt;
  logic             sub_wrap;
  logic             phase_wrap;

  assign sub_wrap   = (sub_cnt == SUB_W'(SUB_DIV - 1));
  assign phase_wrap = sub_wrap && (phase == '1);
  assign boundary   = phase_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      phase   <= '0;
      idx     <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) phase <= phase + 1'b1;
      if (phase_wrap) idx <= boundary ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment driver with per-digit dp/blanking, leading-zero
// suppression, PWM brightness and frame-synchronous data update.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SUB_DIV    = 1562,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int   IDX_W = $clog2(NUM_DIGITS);
  localparam logic INV   = (ACTIVE_LOW != 0);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz;
  } disp_t;

  logic [BRIGHT_W-1:0] phase;
  logic [IDX_W-1:0]    idx;
  logic                boundary;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SUB_DIV    (SUB_DIV),
    .BRIGHT_W   (BRIGHT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase    (phase),
    .idx      (idx),
    .boundary (boundary)
  );

  disp_t in_data, pend, act;
  logic  pend_vld;

  assign in_data = {bus.digits, bus.dp_mask, bus.blank_mask, bus.lz_suppress};

  always_ff @(posedge clk) begin
    if (bus.load) pend <= in_data;
  end

  // Active data only changes at the frame boundary so a frame never tears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      act      <= {{(4*NUM_DIGITS){1'b0}}, {NUM_DIGITS{1'b0}}, {NUM_DIGITS{1'b1}}, 1'b0};
    end else if (boundary) begin
      pend_vld <= 1'b0;
      if (bus.load)     act <= in_data;
      else if (pend_vld) act <= pend;
    end else if (bus.load) begin
      pend_vld <= 1'b1;
    end
  end

  logic [3:0]            cur_nib;
  logic                  upper_zero;
  logic                  suppressed;
  logic                  lit;
  logic [NUM_DIGITS-1:0] en_p0;
  logic [SEG_W-1:0]      cx_p0;

  // Stage 0: decode current slot from counters and active data
  always_comb begin
    cur_nib    = act.digits[int'(idx)*4 +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && act.digits[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    suppressed = act.lz && (idx != '0) && upper_zero;
    lit        = !act.blank[idx] && (phase <= bus.bright);
    en_p0      = '0;
    cx_p0      = '0;
    if (lit) begin
      en_p0[idx]    = 1'b1;
      cx_p0[SEG_DP] = act.dp[idx];
      if (!suppressed) cx_p0[SEG_G:SEG_A] = seg_decode(cur_nib);
    end
  end

  // Stage 1: registered pin drivers, polarity applied here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.en          <= {NUM_DIGITS{INV}};
      bus.cx          <= {SEG_W{INV}};
      bus.frame_start <= 1'b0;
    end else begin
      bus.en          <= en_p0 ^ {NUM_DIGITS{INV}};
      bus.cx          <= cx_p0 ^ {SEG_W{INV}};
      bus.frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model predicts
// every output cycle, a monitor compares on the falling edge.
module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int SD    = 2;
  localparam int BW    = 2;
  localparam int SLOT  = SD * (1 << BW);
  localparam int FRAME = SLOT * N;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
  } disp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .SUB_DIV    (SD),
    .BRIGHT_W   (BW),
    .ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [12:0] expq[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  disp_t act_m, pend_m;
  bit    pv_m = 1'b0;

  // Pin image {frame_start, en, cx} of a frame position, active-low
  function automatic logic [12:0] model_out(int pos, disp_t a, logic [1:0] br);
    int idx, ph, msd;
    logic [3:0] en;
    logic [7:0] cx;
    idx = pos / SLOT;
    ph  = (pos % SLOT) / SD;
    msd = 0;
    for (int i = 0; i < N; i++) if (a.d[4*i +: 4] != 4'h0) msd = i;
    en = 4'h0;
    cx = 8'h00;
    if (!a.bl[idx] && ph <= int'(br)) begin
      en[idx] = 1'b1;
      cx[7]   = a.dp[idx];
      if (!(a.lz && idx > msd)) cx[6:0] = tbl[a.d[4*idx +: 4]];
    end
    return {pos == FRAME - 1, ~en, ~cx};
  endfunction

  task automatic step();
    logic [12:0] e;
    int pos;
    disp_t inp;
    inp = {bus.digits, bus.dp_mask, bus.blank_mask, bus.lz_suppress};
    if (!rst_n) begin
      e     = {1'b0, 4'hF, 8'hFF};
      cyc   = 0;
      pv_m  = 1'b0;
      act_m = '{d: 16'h0, dp: 4'h0, bl: 4'hF, lz: 1'b0};
    end else begin
      pos = cyc % FRAME;
      e   = model_out(pos, act_m, bus.bright);
      if (pos == FRAME - 1) begin
        if (bus.load) act_m = inp;
        else if (pv_m) act_m = pend_m;
        pv_m = 1'b0;
      end else if (bus.load) begin
        pend_m = inp;
        pv_m   = 1'b1;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    expq.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz);
    bus.digits      = d;
    bus.dp_mask     = dp;
    bus.blank_mask  = bl;
    bus.lz_suppress = lz;
    bus.load        = 1'b1;
    step();
    bus.load        = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [12:0] e, got;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = {bus.frame_start, bus.en, bus.cx};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL pins @%0t: got fs=%b en=%h cx=%h, expected fs=%b en=%h cx=%h",
                 $time, got[12], got[11:8], got[7:0], e[12], e[11:8], e[7:0]);
      end
    end
  end

  initial begin
    bus.digits      = '0;
    bus.dp_mask     = '0;
    bus.blank_mask  = '0;
    bus.lz_suppress = 1'b0;
    bus.bright      = 2'd3;
    bus.load        = 1'b0;
    rst_n           = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2 * FRAME) step();

    do_load(16'h12AF, 4'b0010, 4'b0000, 1'b0);
    repeat (2 * FRAME) step();
    bus.bright = 2'd0;
    repeat (FRAME) step();
    bus.bright = 2'd2;
    repeat (FRAME) step();
    bus.bright = 2'd3;

    do_load(16'h0030, 4'b0000, 4'b0000, 1'b1);
    repeat (2 * FRAME) step();
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    repeat (2 * FRAME) step();

    // Two loads inside one frame; only the later one should show
    repeat (10) step();
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    step();
    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    repeat (2 * FRAME + 16) step();

    while (cyc % FRAME != FRAME - 1) step();
    do_load(16'h3333, 4'b0101, 4'b0000, 1'b0);
    repeat (FRAME + 8) step();

    // Reset with a pending load outstanding
    do_load(16'h4444, 4'b1111, 4'b0000, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2 * FRAME + 6) step();

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        logic [15:0] d;
        for (int i = 0; i < N; i++)
          d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        bus.digits      = d;
        bus.dp_mask     = 4'($urandom);
        bus.blank_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        bus.lz_suppress = 1'($urandom);
        bus.load        = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) bus.bright = 2'($urandom);
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      step();
      bus.load = 1'b0;
      rst_n    = 1'b1;
    end

    @(negedge clk);
    #1;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d outstanding, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
